ramp_checker: RTL and testbench

//   Receive-side checker for the ramp stream produced by the team's counter.

---
 rtl/ramp_checker.sv | 131 +++++++++++++
 tb/tb_ramp_checker.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ramp_checker.sv
// Ramp-stream checker: predicts each sample from the previous valid one, locks after
// LOCK_COUNT good predictions, and counts mismatches and checked samples while locked.
module ramp_checker #(
  parameter int DATA_WIDTH   = 8,
  parameter int COUNT_FROM   = 0,
  parameter int COUNT_TO     = 255,
  parameter int STEP         = 1,
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 3,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  clr,
  output logic                  locked,
  output logic                  err,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [CNT_WIDTH-1:0]  sample_count
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int MW = $clog2(UNLOCK_COUNT + 1);
  localparam logic [DATA_WIDTH-1:0] FROM_V = DATA_WIDTH'(COUNT_FROM);
  localparam logic [DATA_WIDTH-1:0] TO_V   = DATA_WIDTH'(COUNT_TO);
  localparam logic [DATA_WIDTH-1:0] STEP_V = DATA_WIDTH'(STEP);

  typedef enum logic [1:0] {HUNT, LOCKING, LOCKED} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] exp_q, exp_d;
  logic [GW-1:0]         good_q, good_d;
  logic [MW-1:0]         miss_q, miss_d;
  logic                  err_q, err_d;
  logic                  locked_q, locked_d;
  logic [CNT_WIDTH-1:0]  err_count_q, err_count_d;
  logic [CNT_WIDTH-1:0]  sample_count_q, sample_count_d;
  logic                  e_inc, s_inc;

  function automatic logic [DATA_WIDTH-1:0] nxt(input logic [DATA_WIDTH-1:0] x);
    nxt = (x < TO_V) ? x + STEP_V : FROM_V;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c,
                                                   input logic inc);
    sat_inc = (inc && (c != '1)) ? c + CNT_WIDTH'(1) : c;
  endfunction

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    good_d  = good_q;
    miss_d  = miss_q;
    err_d   = 1'b0;
    e_inc   = 1'b0;
    s_inc   = 1'b0;
    if (en) begin
      // Predicting from din (not exp) re-syncs after a bad sample.
      exp_d = nxt(din);
      unique case (state_q)
        HUNT: begin
          good_d  = '0;
          state_d = LOCKING;
        end
        LOCKING: begin
          if (din == exp_q) begin
            if (good_q == GW'(LOCK_COUNT - 1)) begin
              // The sample that completes the lock is the first one counted.
              state_d = LOCKED;
              good_d  = '0;
              miss_d  = '0;
              s_inc   = 1'b1;
            end else begin
              good_d = good_q + GW'(1);
            end
          end else begin
            good_d = '0;
          end
        end
        LOCKED: begin
          s_inc = 1'b1;
          if (din == exp_q) begin
            miss_d = '0;
          end else begin
            err_d = 1'b1;
            e_inc = 1'b1;
            if (miss_q == MW'(UNLOCK_COUNT - 1)) begin
              state_d = HUNT;
              miss_d  = '0;
            end else begin
              miss_d = miss_q + MW'(1);
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
    locked_d       = (state_d == LOCKED);
    err_count_d    = sat_inc(clr ? '0 : err_count_q, e_inc);
    sample_count_d = sat_inc(clr ? '0 : sample_count_q, s_inc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= HUNT;
      exp_q          <= FROM_V;
      good_q         <= '0;
      miss_q         <= '0;
      err_q          <= 1'b0;
      locked_q       <= 1'b0;
      err_count_q    <= '0;
      sample_count_q <= '0;
    end else begin
      state_q        <= state_d;
      exp_q          <= exp_d;
      good_q         <= good_d;
      miss_q         <= miss_d;
      err_q          <= err_d;
      locked_q       <= locked_d;
      err_count_q    <= err_count_d;
      sample_count_q <= sample_count_d;
    end
  end

  assign locked       = locked_q;
  assign err          = err_q;
  assign err_count    = err_count_q;
  assign sample_count = sample_count_q;

endmodule

// File: tb/tb_ramp_checker.sv
// Bench for ramp_checker: three instances (default, COUNT_TO=200/STEP=7, CNT_WIDTH=4)
// compared every cycle against a sample-history reference model, plus directed checks.
module tb_ramp_checker;

  localparam int LOCK   = 4;
  localparam int UNLOCK = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       en_a[3];
  logic [7:0] din_a[3];
  logic       clr_a[3];
  logic       lk[3];
  logic       er[3];
  logic [31:0] ec0, sc0, ec1, sc1;
  logic [3:0]  ec2, sc2;

  ramp_checker u0 (.clk(clk), .rst(rst), .en(en_a[0]), .din(din_a[0]), .clr(clr_a[0]),
                   .locked(lk[0]), .err(er[0]), .err_count(ec0), .sample_count(sc0));
  ramp_checker #(.COUNT_TO(200), .STEP(7)) u1 (.clk(clk), .rst(rst), .en(en_a[1]),
                   .din(din_a[1]), .clr(clr_a[1]), .locked(lk[1]), .err(er[1]),
                   .err_count(ec1), .sample_count(sc1));
  ramp_checker #(.CNT_WIDTH(4)) u2 (.clk(clk), .rst(rst), .en(en_a[2]), .din(din_a[2]),
                   .clr(clr_a[2]), .locked(lk[2]), .err(er[2]), .err_count(ec2),
                   .sample_count(sc2));

  int P_TO[3]   = '{255, 200, 255};
  int P_STEP[3] = '{1, 7, 1};
  int P_FROM[3] = '{0, 0, 0};
  int P_CW[3]   = '{32, 32, 4};

  int total = 0;
  int bad   = 0;

  // Reference model: remembers the last valid sample and run lengths.
  int     m_last[3];
  bit     m_hunt[3];
  bit     m_lock[3];
  bit     m_err[3];
  int     m_good[3];
  int     m_miss[3];
  longint m_ec[3];
  longint m_sc[3];
  int     g[3];

  function automatic int nxt(int k, int x);
    return (x < P_TO[k]) ? ((x + P_STEP[k]) % 256) : P_FROM[k];
  endfunction

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] obs_ec(int k);
    case (k)
      0:       return 64'(ec0);
      1:       return 64'(ec1);
      default: return 64'(ec2);
    endcase
  endfunction

  function automatic logic [63:0] obs_sc(int k);
    case (k)
      0:       return 64'(sc0);
      1:       return 64'(sc1);
      default: return 64'(sc2);
    endcase
  endfunction

  task automatic model_step();
    int ei, si, d, p;
    longint mx;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_hunt[k] = 1; m_lock[k] = 0; m_err[k] = 0;
        m_ec[k] = 0; m_sc[k] = 0; m_good[k] = 0; m_miss[k] = 0;
      end else begin
        ei = 0; si = 0; m_err[k] = 0;
        if (en_a[k]) begin
          d = int'(din_a[k]);
          p = nxt(k, m_last[k]);
          if (m_hunt[k]) begin
            m_hunt[k] = 0; m_good[k] = 0;
          end else if (!m_lock[k]) begin
            if (d == p) begin
              m_good[k]++;
              if (m_good[k] == LOCK) begin m_lock[k] = 1; m_miss[k] = 0; si = 1; end
            end else m_good[k] = 0;
          end else begin
            si = 1;
            if (d != p) begin
              m_err[k] = 1; ei = 1; m_miss[k]++;
              if (m_miss[k] == UNLOCK) begin m_lock[k] = 0; m_hunt[k] = 1; end
            end else m_miss[k] = 0;
          end
          m_last[k] = d;
        end
        mx = (longint'(1) << P_CW[k]) - 1;
        m_ec[k] = (clr_a[k] ? 0 : m_ec[k]) + ei;
        if (m_ec[k] > mx) m_ec[k] = mx;
        m_sc[k] = (clr_a[k] ? 0 : m_sc[k]) + si;
        if (m_sc[k] > mx) m_sc[k] = mx;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("locked%0d", k), 64'(lk[k]), 64'(m_lock[k]));
      chk($sformatf("err%0d", k), 64'(er[k]), 64'(m_err[k]));
      chk($sformatf("err_count%0d", k), obs_ec(k), 64'(m_ec[k]));
      chk($sformatf("sample_count%0d", k), obs_sc(k), 64'(m_sc[k]));
    end
  endtask

  task automatic idle();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      en_a[k] = 1'b0; din_a[k] = 8'h00; clr_a[k] = 1'b0;
    end
  endtask

  task automatic feed(int k, int d, bit c);
    idle();
    en_a[k]  = 1'b1;
    din_a[k] = d[7:0];
    clr_a[k] = c;
    tick();
  endtask

  task automatic ramp(int k, int n);
    repeat (n) begin
      feed(k, g[k], 1'b0);
      g[k] = nxt(k, g[k]);
    end
  endtask

  initial begin
    int b;
    idle();
    for (int k = 0; k < 3; k++) begin g[k] = 0; m_last[k] = 0; end
    rst = 1'b1;
    tick();
    tick();
    chk("reset_locked", 64'(lk[0]), 64'd0);
    rst = 1'b0;

    // Clean ramp: lock on the 5th sample, sample_count = N-4.
    ramp(0, 4);
    chk("t1_not_locked", 64'(lk[0]), 64'd0);
    ramp(0, 1);
    chk("t1_locked", 64'(lk[0]), 64'd1);
    ramp(0, 295);
    chk("t1_sample_count", 64'(sc0), 64'd296);
    chk("t1_err_count", 64'(ec0), 64'd0);

    // Single bad sample costs one error, then re-syncs.
    idle(); clr_a[0] = 1'b1; tick();
    while (g[0] != 8'h40) ramp(0, 1);
    feed(0, 8'h55, 1'b0);
    chk("t2_err_pulse", 64'(er[0]), 64'd1);
    chk("t2_err_count", 64'(ec0), 64'd1);
    g[0] = nxt(0, 8'h55);
    ramp(0, 1);
    chk("t2_err_clear", 64'(er[0]), 64'd0);
    chk("t2_still_locked", 64'(lk[0]), 64'd1);

    // Three consecutive bad samples drop lock; relock after 1+LOCK_COUNT.
    idle(); clr_a[0] = 1'b1; tick();
    feed(0, 8'h10, 1'b0);
    feed(0, 8'h90, 1'b0);
    feed(0, 8'h33, 1'b0);
    chk("t3_err_count", 64'(ec0), 64'd3);
    chk("t3_unlocked", 64'(lk[0]), 64'd0);
    ramp(0, 4);
    chk("t3_not_relocked", 64'(lk[0]), 64'd0);
    ramp(0, 1);
    chk("t3_relocked", 64'(lk[0]), 64'd1);

    // STEP=7, COUNT_TO=200: three laps including the 203->0 reload.
    ramp(1, 90);
    chk("t4_err_count", 64'(ec1), 64'd0);
    chk("t4_sample_count", 64'(sc1), 64'd86);
    chk("t4_locked", 64'(lk[1]), 64'd1);

    // clr together with a mismatch leaves exactly one error.
    b = g[0] ^ 8'hFF;
    feed(0, b, 1'b1);
    chk("t6_clr_mismatch", 64'(ec0), 64'd1);
    g[0] = nxt(0, b);
    chk("t6_pre_rst_locked", 64'(lk[0]), 64'd1);

    // Reset mid-lock wins over en and clr.
    idle(); rst = 1'b1; en_a[0] = 1'b1; clr_a[0] = 1'b1; din_a[0] = g[0][7:0];
    tick();
    chk("t6_rst_locked", 64'(lk[0]), 64'd0);
    chk("t6_rst_err_count", 64'(ec0), 64'd0);
    chk("t6_rst_sample_count", 64'(sc0), 64'd0);
    idle();
    m_last[0] = 0;
    for (int k = 1; k < 3; k++) g[k] = (k == 1) ? 0 : g[k];

    // 4-bit counters saturate at 15.
    g[2] = 0;
    ramp(2, 5);
    chk("t6_cnt4_locked", 64'(lk[2]), 64'd1);
    repeat (20) begin
      b = g[2] ^ 8'h80;
      feed(2, b, 1'b0);
      g[2] = nxt(2, b);
      ramp(2, 1);
    end
    chk("t6_cnt4_sat", 64'(ec2), 64'd15);
    chk("t6_cnt4_still_locked", 64'(lk[2]), 64'd1);

    // Random en gaps on a clean ramp.
    g[0] = $urandom_range(0, 255);
    repeat (400) begin
      idle();
      if ($urandom_range(0, 1) == 1) begin
        en_a[0] = 1'b1; din_a[0] = g[0][7:0]; g[0] = nxt(0, g[0]);
      end
      tick();
    end
    chk("t5_err_count", 64'(ec0), 64'd0);

    // Random en, corruption and clr on all instances.
    repeat (600) begin
      idle();
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(0, 3) != 0) begin
          en_a[k]  = 1'b1;
          din_a[k] = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : g[k][7:0];
          g[k]     = nxt(k, g[k]);
        end
        clr_a[k] = ($urandom_range(0, 15) == 0);
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
